// File: rtl/arbiter_rr_n.sv
// N-way request arbiter with round-robin or fixed priority and a bounded
// hold time per owner. Grant, grant_id and grant_valid are all registered.
module arbiter_rr_n #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 4,
  parameter int MODE     = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         request,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 grant_valid
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(MAX_HOLD + 2);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]    state, state_n;
  logic [IW-1:0] ptr, ptr_n;
  logic [IW-1:0] id_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [N-1:0]  grant_n;
  logic [N-1:0]  arb_vec;
  logic [N-1:0]  masked;
  logic          do_arb;
  logic          expired;

  // First set bit of vec scanning upward from start, wrapping N-1 -> 0.
  function automatic logic [IW-1:0] pick(input logic [N-1:0] vec, input logic [IW-1:0] start);
    logic [IW-1:0] res;
    int idx;
    res = {IW{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      idx = int'(start) + i;
      if (idx >= N) begin
        idx = idx - N;
      end else begin
        idx = idx;
      end
      if (vec[idx]) begin
        res = IW'(idx);
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] owner);
    logic [IW-1:0] res;
    if (int'(owner) == N - 1) begin
      res = {IW{1'b0}};
    end else begin
      res = owner + {{(IW-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

  assign masked  = request & ~grant;
  assign expired = (MAX_HOLD != 0) && (cnt >= CW'(MAX_HOLD));

  // Next-state decision: idle pickup, hold, owner drop, or hold expiry.
  always_comb begin
    state_n = state;
    id_n    = grant_id;
    cnt_n   = cnt;
    ptr_n   = ptr;
    arb_vec = request;
    do_arb  = 1'b0;
    case (state)
      IDLE: begin
        if (request != {N{1'b0}}) begin
          do_arb = 1'b1;
        end else begin
          id_n  = {IW{1'b0}};
          cnt_n = {CW{1'b0}};
        end
      end
      BUSY: begin
        if (!request[grant_id]) begin
          // Owner drop wins over a coincident expiry.
          if (request != {N{1'b0}}) begin
            do_arb = 1'b1;
          end else begin
            state_n = IDLE;
            id_n    = {IW{1'b0}};
            cnt_n   = {CW{1'b0}};
          end
        end else if (expired) begin
          if (masked != {N{1'b0}}) begin
            arb_vec = masked;
            do_arb  = 1'b1;
          end else begin
            cnt_n = {{(CW-1){1'b0}}, 1'b1};
            ptr_n = next_ptr(grant_id);
          end
        end else begin
          if (cnt == {CW{1'b1}}) begin
            cnt_n = cnt;
          end else begin
            cnt_n = cnt + {{(CW-1){1'b0}}, 1'b1};
          end
        end
      end
      default: begin
        state_n = IDLE;
        id_n    = {IW{1'b0}};
        cnt_n   = {CW{1'b0}};
      end
    endcase

    if (do_arb) begin
      id_n    = pick(arb_vec, (MODE == 1) ? {IW{1'b0}} : ptr);
      state_n = BUSY;
      cnt_n   = {{(CW-1){1'b0}}, 1'b1};
      ptr_n   = next_ptr(id_n);
    end else begin
      id_n = id_n;
    end

    if (state_n == BUSY) begin
      grant_n = {{(N-1){1'b0}}, 1'b1} << id_n;
    end else begin
      grant_n = {N{1'b0}};
    end
  end

  // State and output registers; reset overrides any arbitration result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= {IW{1'b0}};
      cnt         <= {CW{1'b0}};
      grant       <= {N{1'b0}};
      grant_id    <= {IW{1'b0}};
      grant_valid <= 1'b0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      cnt         <= cnt_n;
      grant       <= grant_n;
      grant_id    <= id_n;
      grant_valid <= (state_n == BUSY);
    end
  end

endmodule

// File: doc/arbiter_rr_n.md
ARBITER_RR_N -- requirements
Module: arbiter_rr_n

Interface
REQ-001 Parameter N, default 4, number of requesters (2..16).
REQ-002 Parameter MAX_HOLD, default 4, maximum consecutive grant cycles per owner; 0 = unlimited.
REQ-003 Parameter MODE, default 0, 0 = round-robin priority, 1 = fixed priority (index 0 highest).
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port rst  input  1  reset, synchronous and active-high.
REQ-006 Port request  input  N  per-requester request level; bit i = requester i.
REQ-007 Port grant  output  N  registered one-hot grant; all-zero when idle.
REQ-008 Port grant_id  output  $clog2(N)  registered index of the granted requester; 0 when idle.
REQ-009 Port grant_valid  output  1  registered; high exactly when grant is non-zero.

Function
REQ-010 The block SHALL be a two-state FSM: IDLE (no owner) and BUSY (one owner holds grant).
REQ-011 All outputs SHALL be registered; request sampled at rising edge k SHALL drive grant after edge k (one-cycle latency).
REQ-012 grant SHALL never have more than one bit set; grant_id SHALL always equal the index of the set bit.
REQ-013 IDLE: request==0 SHALL keep IDLE; any request bit set SHALL grant the winner and enter BUSY.
REQ-014 Winner, MODE=0: first set bit searching upward from priority pointer ptr, wrapping N-1 -> 0.
REQ-015 Winner, MODE=1: lowest-index set bit; ptr ignored.
REQ-016 ptr SHALL be log2(N) bits and update to (owner+1) mod N on every grant issue, wrapping at N-1 -> 0.
REQ-017 Hold counter SHALL load 1 on each grant issue and increment each further BUSY cycle; saturates, never wraps.
REQ-018 BUSY, owner request high and (MAX_HOLD==0 or counter<MAX_HOLD): grant SHALL be held unchanged.
REQ-019 BUSY, owner request low at an edge: grant SHALL move at that edge to the winner among remaining requests (no idle bubble), or to IDLE (grant=0) if none.
REQ-020 BUSY, owner request high and counter==MAX_HOLD: arbitration SHALL run with owner bit masked; if masked vector empty the owner SHALL be re-granted with counter reloaded to 1.
REQ-021 A requester dropping request while not owner SHALL have no effect on state.
REQ-022 Request changes during a held grant SHALL affect only the next arbitration decision.
REQ-023 Simultaneous owner drop and hold expiry SHALL be treated as owner drop (REQ-019).

Reset
REQ-024 rst high at an edge SHALL force IDLE, grant=0, grant_id=0, grant_valid=0, ptr=0, counter=0, regardless of request.
REQ-025 Reset SHALL override any in-progress grant in the same edge; no grant SHALL issue at the edge where rst is sampled high.
REQ-026 First arbitration after reset release SHALL use ptr=0.

Verification (N=4, MAX_HOLD=4 unless stated)
REQ-027 rst high 2 cycles with request=4'b1111 -> grant=0000, grant_valid=0, grant_id=0 throughout.
REQ-028 After reset, request=0001 constant -> grant=0001, grant_id=0 one edge later, held continuously (expiry re-grants sole owner, no gap).
REQ-029 MODE=0, request=1111 constant -> grant 0001 x4 cycles, 0010 x4, 0100 x4, 1000 x4, then 0001 (wrap).
REQ-030 Owner 0010 with request=1010, then request=1000 -> grant=1000, grant_id=3 on next edge, no zero cycle; then request=0000 -> grant=0000, grant_valid=0 next edge.
REQ-031 MODE=1, request=1100 constant -> grant 0100 x4, 1000 x4, 0100 x4 (expiry masking forces alternation).
REQ-032 MODE=0, owner 0100 mid-hold, rst pulsed 1 cycle with request=1111 -> grant=0000 at that edge, then 0001 on first edge after release.
